// File: rtl/tfc_pkg.sv
// tfc_pkg: shared types for the traffic light controller.
//   phase_t     - phase codes, also presented on phase_o
//   target_t    - where the next ALL_RED clearance leads
//   LAMP_*      - two-bit lamp encodings for main_l / side_l
//   lamps_t     - bundle of all lamp outputs
//   phase_lamps - lamp pattern shown during a given phase
package tfc_pkg;

    typedef enum logic [2:0] {
        PH_MAIN_GREEN  = 3'd0,
        PH_MAIN_YELLOW = 3'd1,
        PH_ALL_RED     = 3'd2,
        PH_SIDE_GREEN  = 3'd3,
        PH_SIDE_YELLOW = 3'd4,
        PH_PED_WALK    = 3'd5
    } phase_t;

    typedef enum logic [1:0] {
        TGT_MAIN = 2'd0,
        TGT_SIDE = 2'd1,
        TGT_PED  = 2'd2
    } target_t;

    localparam logic [1:0] LAMP_GREEN  = 2'b10;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b00;

    typedef struct packed {
        logic [1:0] main_l;
        logic [1:0] side_l;
        logic       ped_l;
    } lamps_t;

    function automatic lamps_t phase_lamps(phase_t p);
        lamps_t l;
        l.main_l = LAMP_RED;
        l.side_l = LAMP_RED;
        l.ped_l  = 1'b0;
        case (p)
            PH_MAIN_GREEN:  l.main_l = LAMP_GREEN;
            PH_MAIN_YELLOW: l.main_l = LAMP_YELLOW;
            PH_SIDE_GREEN:  l.side_l = LAMP_GREEN;
            PH_SIDE_YELLOW: l.side_l = LAMP_YELLOW;
            PH_PED_WALK:    l.ped_l  = 1'b1;
            default:        ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tfc_debounce.sv
// tfc_debounce: side-road sensor debounce and request flag.
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   sense - raw vehicle sensor level
//   clr   - clears pend (controller is entering SIDE_GREEN); wins over set
//   pend  - side request registered after SENSE_CNT consecutive high cycles
module tfc_debounce #(
    parameter int SENSE_CNT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sense,
    input  logic clr,
    output logic pend
);
    import tfc_pkg::*;

    localparam int            CW     = $clog2(SENSE_CNT + 1);
    localparam logic [CW-1:0] SAT    = CW'(SENSE_CNT);
    localparam logic [CW-1:0] SAT_M1 = CW'(SENSE_CNT - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] cnt;

    // pend is set on the edge where the count reaches SENSE_CNT, so a
    // sensor high from cycle k shows pend at cycle k+SENSE_CNT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            if (!sense)
                cnt <= '0;
            else if (cnt != SAT)
                cnt <= cnt + ONE;

            if (clr)
                pend <= 1'b0;
            else if (sense && (cnt >= SAT_M1))
                pend <= 1'b1;
        end
    end

endmodule

// File: rtl/tfc_ctrl_param.sv
// tfc_ctrl_param: two-road traffic light controller with pedestrian phase.
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   ped_req    - pedestrian button, single-cycle pulse is enough
//   side_sense - side-road vehicle sensor level
//   main_l     - main lamp (10 green, 01 yellow, 00 red), registered
//   side_l     - side lamp, same encoding, registered
//   ped_l      - walk lamp, registered
//   phase_o    - current phase code, registered
// Build option: define TFC_PED_EN to enable the pedestrian latch and
// PED_WALK phase; without it ped_req is ignored and ped_l stays 0.
module tfc_ctrl_param #(
    parameter int CNT_W      = 8,
    parameter int MAIN_MIN   = 16,
    parameter int YELLOW     = 3,
    parameter int ALL_RED    = 2,
    parameter int SIDE_GREEN = 8,
    parameter int PED_WALK   = 6,
    parameter int SENSE_CNT  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_req,
    input  logic       side_sense,
    output logic [1:0] main_l,
    output logic [1:0] side_l,
    output logic       ped_l,
    output logic [2:0] phase_o
);
    import tfc_pkg::*;

    // Timer reload values are duration-1 so each phase lasts exactly D cycles.
    localparam logic [CNT_W-1:0] T_MAIN   = CNT_W'(MAIN_MIN - 1);
    localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] T_SIDE   = CNT_W'(SIDE_GREEN - 1);
    localparam logic [CNT_W-1:0] T_PED    = CNT_W'(PED_WALK - 1);
    localparam logic [CNT_W-1:0] T_ONE    = CNT_W'(1);

`ifdef TFC_PED_EN
    localparam logic PED_EN = 1'b1;
`else
    localparam logic PED_EN = 1'b0;
`endif

    phase_t           phase, phase_nxt;
    target_t          target, target_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic             side_pend, ped_pend;
    logic             enter_side;
    lamps_t           lamps_nxt;

    function automatic logic [CNT_W-1:0] dur_m1(phase_t p);
        case (p)
            PH_MAIN_GREEN:  return T_MAIN;
            PH_MAIN_YELLOW: return T_YELLOW;
            PH_SIDE_YELLOW: return T_YELLOW;
            PH_ALL_RED:     return T_ALLRED;
            PH_SIDE_GREEN:  return T_SIDE;
            PH_PED_WALK:    return T_PED;
            default:        return T_MAIN;
        endcase
    endfunction

    // Next-phase decision. A phase only moves on when its timer is 0;
    // MAIN_GREEN simply parks at timer 0 until a request is pending.
    // No phase transitions to itself, so a phase change always reloads.
    always_comb begin
        phase_nxt  = phase;
        target_nxt = target;
        timer_nxt  = timer;
        if (timer != '0) begin
            timer_nxt = timer - T_ONE;
        end else begin
            case (phase)
                PH_MAIN_GREEN: begin
                    if (ped_pend) begin
                        target_nxt = TGT_PED;
                        phase_nxt  = PH_MAIN_YELLOW;
                    end else if (side_pend) begin
                        target_nxt = TGT_SIDE;
                        phase_nxt  = PH_MAIN_YELLOW;
                    end
                end
                PH_MAIN_YELLOW: phase_nxt = PH_ALL_RED;
                PH_ALL_RED: begin
                    case (target)
                        TGT_SIDE: phase_nxt = PH_SIDE_GREEN;
`ifdef TFC_PED_EN
                        TGT_PED:  phase_nxt = PH_PED_WALK;
`endif
                        default:  phase_nxt = PH_MAIN_GREEN;
                    endcase
                end
                PH_SIDE_GREEN: phase_nxt = PH_SIDE_YELLOW;
                PH_SIDE_YELLOW: begin
                    phase_nxt  = PH_ALL_RED;
                    target_nxt = TGT_MAIN;
                end
                PH_PED_WALK: begin
                    phase_nxt  = PH_ALL_RED;
                    target_nxt = TGT_MAIN;
                end
                default: phase_nxt = PH_MAIN_GREEN;
            endcase
            if (phase_nxt != phase)
                timer_nxt = dur_m1(phase_nxt);
        end
    end

    assign enter_side = (phase_nxt == PH_SIDE_GREEN) && (phase != PH_SIDE_GREEN);
    assign lamps_nxt  = phase_lamps(phase_nxt);

    tfc_debounce #(
        .SENSE_CNT (SENSE_CNT)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .sense (side_sense),
        .clr   (enter_side),
        .pend  (side_pend)
    );

`ifdef TFC_PED_EN
    logic enter_ped;
    assign enter_ped = (phase_nxt == PH_PED_WALK) && (phase != PH_PED_WALK);

    // Clear on PED_WALK entry has priority, so a press in that same cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n)
            ped_pend <= 1'b0;
        else if (enter_ped)
            ped_pend <= 1'b0;
        else if (ped_req && (phase != PH_PED_WALK))
            ped_pend <= 1'b1;
    end
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_pend       = 1'b0;
`endif

    // Lamps are registered from the next phase so they change on the
    // same edge as the phase register and never glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase   <= PH_MAIN_GREEN;
            timer   <= T_MAIN;
            target  <= TGT_MAIN;
            main_l  <= LAMP_GREEN;
            side_l  <= LAMP_RED;
            ped_l   <= 1'b0;
            phase_o <= 3'd0;
        end else begin
            phase   <= phase_nxt;
            timer   <= timer_nxt;
            target  <= target_nxt;
            main_l  <= lamps_nxt.main_l;
            side_l  <= lamps_nxt.side_l;
            ped_l   <= lamps_nxt.ped_l & PED_EN;
            phase_o <= phase_nxt;
        end
    end

endmodule

// File: tb/tb_tfc_ctrl_param.sv
// tb_tfc_ctrl_param: scoreboard bench for tfc_ctrl_param with default
// parameters. Stimulus tasks queue the expected phase per cycle; a monitor
// samples the DUT on every falling edge and compares against the queue head.
// Cycle 0 is the sample just before the first rising edge with rst_n=1.
// Pedestrian expectations follow the TFC_PED_EN build option.
`timescale 1ns/1ps
module tb_tfc_ctrl_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ped_req = 1'b0;
    logic       side_sense = 1'b0;
    logic [1:0] main_l;
    logic [1:0] side_l;
    logic       ped_l;
    logic [2:0] phase_o;

    tfc_ctrl_param dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ped_req    (ped_req),
        .side_sense (side_sense),
        .main_l     (main_l),
        .side_l     (side_l),
        .ped_l      (ped_l),
        .phase_o    (phase_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tick;
        int         cyc;
        logic [2:0] ph;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   tick = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Lamp pattern {main_l, side_l, ped_l} for a phase code.
    function automatic logic [4:0] lampsFor(logic [2:0] ph);
        case (ph)
            3'd0:    return 5'b10_00_0;
            3'd1:    return 5'b01_00_0;
            3'd3:    return 5'b00_10_0;
            3'd4:    return 5'b00_01_0;
            3'd5:    return 5'b00_00_1;
            default: return 5'b00_00_0;
        endcase
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [4:0] want;
        want = lampsFor(e.ph);
        vectors++;
        if (e.tick != tick) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: sampled at tick %0d, required tick %0d",
                     e.name, e.cyc, tick, e.tick);
        end else if ({main_l, side_l, ped_l} !== want || phase_o !== e.ph) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got main=%b side=%b ped=%b phase=%0d, want main=%b side=%b ped=%b phase=%0d",
                     e.name, e.cyc, main_l, side_l, ped_l, phase_o,
                     want[4:3], want[2:1], want[0], e.ph);
        end
    endtask

    // Monitor: one DUT sample per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            tick++;
            while (sb.size() > 0 && sb[0].tick <= tick) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic expectRange(input int base, input int from, input int to,
                               input logic [2:0] ph, input string name);
        exp_t e;
        for (int k = from; k <= to; k++) begin
            e.tick = base + k;
            e.cyc  = k;
            e.ph   = ph;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Wait until cycle k of the current scenario, then drive the inputs.
    task automatic applyStimulus(input int base, input int k, input logic side, input logic ped);
        int guard;
        guard = 0;
        while (tick < base + k && guard < 1000) begin
            waitCycles(1);
            guard++;
        end
        if (tick != base + k) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL stim_align: at tick %0d, required tick %0d", tick, base + k);
        end
        side_sense = side;
        ped_req    = ped;
    endtask

    // Two reset edges, both checked; returns the tick of cycle 0.
    task automatic applyReset(output int base);
        rst_n      = 1'b0;
        side_sense = 1'b0;
        ped_req    = 1'b0;
        expectRange(tick, 1, 2, 3'd0, "reset");
        waitCycles(2);
        rst_n = 1'b1;
        base  = tick;
    endtask

    initial begin
        int base;
        int base2;
        int guard;

        @(negedge clk);
        #1;

        // Side request held from cycle 0: one full side cycle.
        applyReset(base);
        side_sense = 1'b1;
        expectRange(base, 1, 15, 3'd0, "side_mg");
        expectRange(base, 16, 18, 3'd1, "side_my");
        expectRange(base, 19, 20, 3'd2, "side_ar1");
        expectRange(base, 21, 28, 3'd3, "side_sg");
        expectRange(base, 29, 31, 3'd4, "side_sy");
        expectRange(base, 32, 33, 3'd2, "side_ar2");
        expectRange(base, 34, 34, 3'd0, "side_back");
        applyStimulus(base, 34, 1'b0, 1'b0);

        // Two-cycle sensor blip stays below the debounce threshold.
        applyReset(base);
        side_sense = 1'b1;
        expectRange(base, 1, 99, 3'd0, "blip_mg");
        applyStimulus(base, 2, 1'b0, 1'b0);
        applyStimulus(base, 99, 1'b0, 1'b0);

`ifdef TFC_PED_EN
        // Pedestrian outranks side; side is served after the next main green.
        applyReset(base);
        side_sense = 1'b1;
        expectRange(base, 1, 15, 3'd0, "ped_mg1");
        expectRange(base, 16, 18, 3'd1, "ped_my1");
        expectRange(base, 19, 20, 3'd2, "ped_ar1");
        expectRange(base, 21, 26, 3'd5, "ped_walk");
        expectRange(base, 27, 28, 3'd2, "ped_ar2");
        expectRange(base, 29, 44, 3'd0, "ped_mg2");
        expectRange(base, 45, 45, 3'd1, "ped_my2");
        applyStimulus(base, 5, 1'b1, 1'b1);
        applyStimulus(base, 6, 1'b1, 1'b0);
        applyStimulus(base, 45, 1'b0, 1'b0);
`else
        // Pedestrian button ignored without the pedestrian build option.
        applyReset(base);
        expectRange(base, 1, 99, 3'd0, "noped_mg");
        applyStimulus(base, 3, 1'b0, 1'b1);
        applyStimulus(base, 4, 1'b0, 1'b0);
        applyStimulus(base, 99, 1'b0, 1'b0);
`endif

        // Reset during SIDE_GREEN aborts straight to MAIN_GREEN and drops requests.
        applyReset(base);
        side_sense = 1'b1;
        expectRange(base, 1, 15, 3'd0, "abort_mg");
        expectRange(base, 16, 18, 3'd1, "abort_my");
        expectRange(base, 19, 20, 3'd2, "abort_ar");
        expectRange(base, 21, 25, 3'd3, "abort_sg");
        applyStimulus(base, 25, 1'b0, 1'b0);
        rst_n = 1'b0;
        expectRange(tick, 1, 1, 3'd0, "abort_reset");
        waitCycles(1);
        rst_n = 1'b1;
        base2 = tick;
        expectRange(base2, 1, 40, 3'd0, "abort_after");
        applyStimulus(base2, 40, 1'b0, 1'b0);

        // Late request while parked at timer 0; side green runs full length after sensor drops.
        applyReset(base);
        expectRange(base, 1, 33, 3'd0, "late_mg");
        expectRange(base, 34, 36, 3'd1, "late_my");
        expectRange(base, 37, 38, 3'd2, "late_ar1");
        expectRange(base, 39, 46, 3'd3, "late_sg");
        expectRange(base, 47, 49, 3'd4, "late_sy");
        expectRange(base, 50, 51, 3'd2, "late_ar2");
        expectRange(base, 52, 52, 3'd0, "late_back");
        applyStimulus(base, 30, 1'b1, 1'b0);
        applyStimulus(base, 33, 1'b0, 1'b0);
        applyStimulus(base, 52, 1'b0, 1'b0);

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            waitCycles(1);
            guard++;
        end
        while (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: never sampled, required phase %0d",
                     sb[0].name, sb[0].cyc, sb[0].ph);
            void'(sb.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/tfc_ctrl_param.md
# tfc_ctrl_param

Parametrised two-road traffic light controller with a pedestrian phase. It drives the main-road, side-road and pedestrian lamps for one junction. Every phase duration comes from a parameter, and all phases are timed by a shared down-counter. It debounces the side-road vehicle sensor and latches pedestrian requests, so short pulses are never lost. The block sits at the top of the junction datapath; its lamp outputs go directly to the lamp drivers.

## Interface
- CNT_W, 8: phase timer width in bits. Every duration parameter must satisfy 1 ≤ value ≤ 2**CNT_W−1.
- MAIN_MIN, 16: minimum main-green duration, in cycles.
- YELLOW, 3: yellow duration for either road, in cycles.
- ALL_RED, 2: all-red clearance between phases, in cycles.
- SIDE_GREEN, 8: side-green duration, in cycles.
- PED_WALK, 6: pedestrian walk duration, in cycles.
- SENSE_CNT, 3: number of consecutive cycles side_sense must be high to register a side request.

- clk, in, 1: sole clock, rising edge.
- rst_n, in, 1: reset. Synchronous, active-low.
- ped_req, in, 1: pedestrian button. A single-cycle pulse is sufficient.
- side_sense, in, 1: side-road vehicle sensor, level input.
- main_l, out, 2: main lamp. 2'b10 = green, 2'b01 = yellow, 2'b00 = red.
- side_l, out, 2: side lamp, same encoding as main_l.
- ped_l, out, 1: walk lamp.
- phase_o, out, 3: current phase code, for debug and verification.

## Operation
- Phases and codes: MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED=2, SIDE_GREEN=3, SIDE_YELLOW=4, PED_WALK=5.
- Lamp values per phase; any lamp not listed is red and ped_l=0:
  - MAIN_GREEN: main_l=10.
  - MAIN_YELLOW: main_l=01.
  - SIDE_GREEN: side_l=10.
  - SIDE_YELLOW: side_l=01.
  - PED_WALK: ped_l=1.
  - ALL_RED: all lamps red, ped_l=0.
- Phase timer:
  - On entry to a phase with duration D, the timer loads D−1 and decrements once per cycle.
  - The phase exits on the cycle in which the timer equals 0, so each phase lasts exactly D cycles.
- Side debounce:
  - A saturating counter increments while side_sense=1 and clears when side_sense=0.
  - side_pend is set when the counter reaches SENSE_CNT.
  - side_pend clears on entry to SIDE_GREEN.
- Pedestrian latch:
  - ped_pend is set on any cycle with ped_req=1, except while in PED_WALK, when ped_req is ignored.
  - ped_pend clears on entry to PED_WALK.
  - If the set and clear events fall in the same cycle, the clear wins and the request is dropped.
- MAIN_GREEN:
  - While the timer is above 0, stay in MAIN_GREEN.
  - When the timer is 0, check for pending requests. With ped_pend or side_pend set, load the target register and go to MAIN_YELLOW. Pedestrian outranks side.
  - With neither pending at timer 0, hold MAIN_GREEN with the timer at 0. A request that arrives later causes exit on the following cycle.
- Target register values: PED when ped_pend is set, otherwise SIDE.
- Transitions:
  - MAIN_YELLOW → ALL_RED.
  - ALL_RED → the target phase: SIDE_GREEN, PED_WALK, or MAIN_GREEN.
  - SIDE_GREEN → SIDE_YELLOW → ALL_RED (target=MAIN).
  - PED_WALK → ALL_RED (target=MAIN).
- Once SIDE_GREEN starts it runs its full duration, even if side_sense falls.
- Lamp outputs and phase_o are registered and update on the same edge as the phase register. Outputs never glitch between phases.
- Reset values, applied on the first clk edge with rst_n=0:
  - phase=MAIN_GREEN, timer=MAIN_MIN−1, target=MAIN.
  - side_pend=0, ped_pend=0, debounce counter=0.
  - main_l=2'b10, side_l=2'b00, ped_l=0, phase_o=0.
- Reset asserted in the middle of any phase aborts that phase immediately. No yellow or all-red phase is inserted.

## Timing
- Cycle 0 is the first edge with rst_n=1; MAIN_GREEN occupies cycles 0 through MAIN_MIN−1.
- Request latency:
  - side_sense high from cycle k sets side_pend visible at cycle k+SENSE_CNT.
  - ped_req at cycle k sets ped_pend visible at cycle k+1.
- Full side cycle, with defaults and a side request already pending: MAIN_GREEN 16, MAIN_YELLOW 3, ALL_RED 2, SIDE_GREEN 8, SIDE_YELLOW 3, ALL_RED 2, then back to MAIN_GREEN.
- Main road is never yellow and side road never green in the same cycle. No two greens are ever active together.

## Configuration
- TFC_PED_EN defined: pedestrian latch, PED_WALK phase and ped_l are fully functional.
- TFC_PED_EN undefined:
  - ped_req is ignored.
  - ped_l is tied to 0.
  - Phase code 5 is never produced.
  - The target register can only hold SIDE or MAIN.

## Structure
- Package tfc_pkg holds:
  - the phase enum with the codes above;
  - lamp encoding constants LAMP_GREEN=2'b10, LAMP_YELLOW=2'b01, LAMP_RED=2'b00;
  - the target enum.
- Sub-module tfc_debounce: the side-sensor saturating counter plus the side_pend flag. Ports: clk, rst_n, sense, clr, pend.

## Test plan
- rst_n low for 2 cycles, then high → main_l=10, side_l=00, ped_l=0 and phase_o=0 from the first reset edge onward.
- side_sense held high from cycle 0 → main_l=10 for cycles 0–15, then 01 for 16–18, all red for 19–20, side_l=10 for 21–28, side_l=01 for 29–31, all red for 32–33, main_l=10 at 34.
- side_sense high for 2 cycles only → side_pend is never set and main_l stays 10 for 100 cycles.
- ped_req pulse at cycle 5 with side_sense high → after main yellow (16–18) and all red (19–20), ped_l=1 for cycles 21–26, then all red 27–28, MAIN_GREEN 29–44. After that the side phase is served, with MAIN_YELLOW starting at cycle 45.
- rst_n low at cycle 25, during SIDE_GREEN → at the next edge main_l=10, side_l=00 and phase_o=0, and the pending flags are cleared.
- Build without TFC_PED_EN, pulse ped_req at cycle 3 → ped_l stays 0 and main_l stays 10 for 100 cycles.
